// File: rtl/shreg_piso_tx_if.sv
// shreg_piso_tx_if: parallel-word input and serial-bit output
// handshakes of the PISO transmitter.
interface shreg_piso_tx_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 3
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             out_last;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_len,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bit,
    output out_last
  );

  modport master (
    output in_valid,
    output in_data,
    output in_len,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bit,
    input  out_last
  );

endinterface

// File: rtl/shreg_piso_tx.sv
// shreg_piso_tx: parallel-in serial-out transmitter, MSB first,
// variable frame length, zero-bubble back-to-back frames.
module shreg_piso_tx #(
  parameter int               WIDTH = 8,
  parameter int               LEN_W = 3,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  shreg_piso_tx_if.slave     bus
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;
  logic             live_q;
  logic             live_d;

  logic [LEN_W-1:0] len_eff;
  logic [LEN_W:0]   shamt;
  logic [WIDTH-1:0] load_word;
  logic             cnt_zero;
  logic             in_ready;
  logic             out_valid;
  logic             out_bit;
  logic             out_last;
  logic             accept;
  logic             beat;

  assign cnt_zero = (cnt_q == '0);
  assign accept   = bus.in_valid & in_ready;
  assign beat     = out_valid & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_bit   = out_bit;
  assign bus.out_last  = out_last;

  // Clamp an illegal length and align bit in_len to the MSB.
  always_comb begin
    len_eff = bus.in_len;
    if ({1'b0, bus.in_len} > MAX_LEN) begin
      len_eff = MAX_LEN[LEN_W-1:0];
    end
    shamt     = MAX_LEN - {1'b0, len_eff};
    load_word = bus.in_data << shamt;
  end

  // State, shift register and counter; live_q holds off in_ready
  // until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sreg_q  <= INIT;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      live_q  <= live_d;
    end
  end

  // Next state: a frame end with a waiting word stays in SHIFT.
  always_comb begin
    state_d = state_q;
    live_d  = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (beat && cnt_zero) begin
          state_d = accept ? S_SHIFT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath update: load on accept, shift on a non-final beat.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (accept) begin
      sreg_d = load_word;
      cnt_d  = len_eff;
    end else if (beat && !cnt_zero) begin
      sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      cnt_d  = cnt_q - 1'b1;
    end
  end

  // Outputs; the only comb path is out_ready -> in_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_bit   = sreg_q[WIDTH-1];
    unique case (state_q)
      S_IDLE: begin
        in_ready = live_q;
      end
      S_SHIFT: begin
        out_valid = 1'b1;
        out_last  = cnt_zero;
        in_ready  = bus.out_ready & cnt_zero;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // A stalled bit must not change under the sink.
  a_stall_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !bus.out_ready) |=>
      (out_valid && $stable(out_bit) && $stable(out_last))
  );

  // The counter never exceeds the longest frame.
  a_cnt_range: assert property (
    @(posedge clk) disable iff (!rst_n)
    ({1'b0, cnt_q} <= MAX_LEN)
  );

endmodule

// File: tb/tb_shreg_piso_tx.sv
// tb_shreg_piso_tx: scoreboard bench for the PISO transmitter.
// Expected bits are queued on accept and popped on each out beat.
module tb_shreg_piso_tx;

  localparam int         WIDTH = 8;
  localparam int         LEN_W = 3;
  localparam logic [7:0] INIT  = 8'h00;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  logic [1:0] q[$];

  shreg_piso_tx_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  shreg_piso_tx #(
    .WIDTH(WIDTH),
    .LEN_W(LEN_W),
    .INIT (INIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: queue frames on accept, compare on every out beat.
  always @(negedge clk) begin
    logic [1:0] e;
    int l;
    if (rst_n) begin
      if (bus.out_valid) vcount++;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: bit=%0b last=%0b, none expected",
                   bus.out_bit, bus.out_last);
        end else begin
          e = q.pop_front();
          if ({bus.out_bit, bus.out_last} !== e) begin
            errors++;
            $display("FAIL beat: bit/last=%b, expected %b",
                     {bus.out_bit, bus.out_last}, e);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        l = (int'(bus.in_len) > WIDTH - 1) ? WIDTH - 1 : int'(bus.in_len);
        for (int i = l; i >= 0; i--) begin
          q.push_back({bus.in_data[i], (i == 0)});
        end
      end
    end
  end

  task automatic drive_word(input logic [7:0] d, input logic [2:0] l,
                            output bit ok);
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.in_data  = d;
    bus.in_len   = l;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.out_valid && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_len    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid: got %b, expected 0", bus.out_valid);
    end
    checks++;
    if (bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_last: got %b, expected 0", bus.out_last);
    end
    checks++;
    if (bus.out_bit !== INIT[7]) begin
      errors++;
      $display("FAIL rst_out_bit: got %b, expected %b", bus.out_bit, INIT[7]);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready: got %b, expected 0", bus.in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rel_in_ready_pre_edge: got %b, expected 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rel_in_ready: got %b, expected 1", bus.in_ready);
    end
  endtask

  task automatic test_single;
    bit ok;
    bus.out_ready = 1'b1;
    vcount = 0;
    drive_word(8'hA5, 3'd7, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_accept: got timeout, expected accept");
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_bit} !== 2'b11) begin
      errors++;
      $display("FAIL single_latency: valid/bit=%b, expected 11",
               {bus.out_valid, bus.out_bit});
    end
    wait_drain(ok);
    checks++;
    if (!ok || vcount != 8) begin
      errors++;
      $display("FAIL single_len: drained=%0b cycles=%0d, expected 1 and 8",
               ok, vcount);
    end
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL single_idle: valid/ready=%b, expected 01",
               {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_short;
    bit ok;
    vcount = 0;
    drive_word(8'hF6, 3'd2, ok);
    wait_drain(ok);
    checks++;
    if (!ok || vcount != 3) begin
      errors++;
      $display("FAIL short_len: drained=%0b cycles=%0d, expected 1 and 3",
               ok, vcount);
    end
  endtask

  task automatic test_back_to_back;
    int acc;
    int vc;
    int rdy9;
    bit rdy8;
    bit seen;
    bit ended;
    acc = 0;
    vc = 0;
    rdy9 = 0;
    rdy8 = 1'b0;
    seen = 1'b0;
    ended = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_data  = 8'h81;
    bus.in_len   = 3'd7;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 60 && !ended; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        vc++;
        if (vc <= 9 && bus.in_ready) rdy9++;
        if (vc == 8) rdy8 = bus.in_ready;
      end else if (seen) begin
        ended = 1'b1;
      end
      if (bus.in_valid && bus.in_ready) begin
        acc++;
        @(posedge clk);
        #1;
        if (acc == 1) begin
          bus.in_data = 8'h03;
          bus.in_len  = 3'd1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (acc != 2) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d, expected 2", acc);
    end
    checks++;
    if (vc != 10) begin
      errors++;
      $display("FAIL b2b_contiguous: got %0d valid cycles, expected 10", vc);
    end
    checks++;
    if (rdy8 !== 1'b1 || rdy9 != 1) begin
      errors++;
      $display("FAIL b2b_in_ready: at8=%0b count=%0d, expected 1 and 1",
               rdy8, rdy9);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d bits left, expected 0", q.size());
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    bit done;
    bit prev_stall;
    bit prev_bit;
    bit prev_last;
    int stalls;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    done = 1'b0;
    prev_stall = 1'b0;
    prev_bit = 1'b0;
    prev_last = 1'b0;
    stalls = 0;
    bus.out_ready = 1'b1;
    drive_word(8'hC3, 3'd7, ok);
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      bus.out_ready = pat[c % 4];
      @(negedge clk);
      if (prev_stall) begin
        stalls++;
        checks++;
        if (!bus.out_valid || bus.out_bit !== prev_bit ||
            bus.out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: v/bit/last=%b%b%b, expected 1%b%b",
                   bus.out_valid, bus.out_bit, bus.out_last,
                   prev_bit, prev_last);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_bit   = bus.out_bit;
      prev_last  = bus.out_last;
      if (!bus.out_valid && q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    bus.out_ready = 1'b1;
    checks++;
    if (!done || stalls == 0) begin
      errors++;
      $display("FAIL bp_done: drained=%0b stalls=%0d, expected 1 and >0",
               done, stalls);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int b;
    b = 0;
    bus.out_ready = 1'b1;
    drive_word(8'hFF, 3'd7, ok);
    for (int c = 0; c < 20 && b < 3; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) b++;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    checks++;
    if ({bus.out_valid, bus.out_last, bus.in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL mid_rst_async: valid/last/ready=%b, expected 000",
               {bus.out_valid, bus.out_last, bus.in_ready});
    end
    checks++;
    if (bus.out_bit !== INIT[7]) begin
      errors++;
      $display("FAIL mid_rst_bit: got %b, expected %b", bus.out_bit, INIT[7]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL mid_rst_release: ready/valid=%b, expected 10",
               {bus.in_ready, bus.out_valid});
    end
    vcount = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (vcount != 0) begin
      errors++;
      $display("FAIL mid_rst_residual: got %0d valid cycles, expected 0",
               vcount);
    end
  endtask

  task automatic test_boundary;
    bit ok;
    bus.out_ready = 1'b1;
    vcount = 0;
    drive_word(8'h01, 3'd0, ok);
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_bit, bus.out_last} !== 3'b111) begin
      errors++;
      $display("FAIL len0_first: v/bit/last=%b, expected 111",
               {bus.out_valid, bus.out_bit, bus.out_last});
    end
    wait_drain(ok);
    checks++;
    if (!ok || vcount != 1) begin
      errors++;
      $display("FAIL len0_len: drained=%0b cycles=%0d, expected 1 and 1",
               ok, vcount);
    end
    vcount = 0;
    drive_word(8'h80, 3'd7, ok);
    wait_drain(ok);
    checks++;
    if (!ok || vcount != 8) begin
      errors++;
      $display("FAIL len7_len: drained=%0b cycles=%0d, expected 1 and 8",
               ok, vcount);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_short();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_boundary();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
